// File: rtl/fll_cfg_pkg.sv
// ---------------------------------------------------------------------------
// fll_cfg_pkg
//
// Shared types and constants for the FLL configuration-port controller:
//   - fll_cfg_state_e : states of the command/handshake FSM
//   - FLL_ADDR_W      : width of the FLL register address
//   - FLL_DATA_W      : width of the FLL register data
//   - fll_cmd_t       : one latched bus command (we, addr, wdata)
// ---------------------------------------------------------------------------
package fll_cfg_pkg;

   localparam int FLL_ADDR_W = 2;
   localparam int FLL_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REQ      = 2'd1,
      ST_WAIT_REL = 2'd2,
      ST_RESP     = 2'd3
   } fll_cfg_state_e;

   typedef struct packed {
      logic                  we;
      logic [FLL_ADDR_W-1:0] addr;
      logic [FLL_DATA_W-1:0] wdata;
   } fll_cmd_t;

endpackage

// File: rtl/fll_lock_monitor.sv
// ---------------------------------------------------------------------------
// fll_lock_monitor
//
// Qualifies the asynchronous FLL lock indication and drives the SoC clock
// select. The lock is brought into clk_i through a 2-flop synchroniser; a
// saturating counter then measures how long the synchronised lock has been
// continuously high. locked_o asserts once the counter reaches LOCK_STABLE;
// clk_sel_o follows one cycle later when software allows the switch.
//
// Parameters:
//   LOCK_STABLE      consecutive synchronised-lock cycles before locked_o
//
// Ports:
//   clk_i            reference clock
//   rst_i            synchronous, active-high reset
//   fll_lock_i       FLL lock, asynchronous to clk_i
//   clk_switch_en_i  software permission to run from the FLL clock
//   locked_o         lock has been stable for LOCK_STABLE cycles
//   clk_sel_o        0 = reference clock, 1 = FLL clock (registered)
// ---------------------------------------------------------------------------
module fll_lock_monitor #(
   parameter int LOCK_STABLE = 64
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic fll_lock_i,
   input  logic clk_switch_en_i,
   output logic locked_o,
   output logic clk_sel_o
);

   localparam int                CNT_W   = $clog2(LOCK_STABLE + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(LOCK_STABLE);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clk_sel_q, clk_sel_d;

   assign locked_o  = (cnt_q == CNT_MAX);
   assign clk_sel_o = clk_sel_q;

   always_comb begin
      sync1_d = fll_lock_i;
      sync2_d = sync1_q;

      cnt_d = cnt_q;
      if (!sync2_q) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end

      // Gating with the synchronised lock makes clk_sel_o fall in the same
      // cycle as locked_o, so a lost lock reverts to the reference clock
      // without an extra cycle on the unlocked FLL.
      clk_sel_d = locked_o && sync2_q && clk_switch_en_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         cnt_q     <= '0;
         clk_sel_q <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         cnt_q     <= cnt_d;
         clk_sel_q <= clk_sel_d;
      end
   end

endmodule

// File: rtl/fll_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// fll_cfg_ctrl
//
// Bus-side controller for the FLL configuration port. A single-beat command
// (valid/ready) is turned into a four-phase req/ack exchange with the FLL:
//   IDLE -> REQ (req held until ack or timeout) -> WAIT_REL (ack released)
//   -> RESP (one-cycle response strobe) -> IDLE.
// A missing ack is aborted after ACK_TIMEOUT REQ cycles with rsp_err_o=1.
// The lock monitor sub-module qualifies fll_lock_i and drives clk_sel_o.
//
// Optional build macro:
//   FLL_CFG_SHADOW_EN  keep a 4x32 shadow of successfully written registers
//                      and answer reads from it without an FLL handshake.
//
// Parameters:
//   ACK_TIMEOUT   REQ cycles to wait for fll_ack_i (2..65535)
//   LOCK_STABLE   stable-lock cycles before locked_o (1..65535)
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   cmd_valid_i/ready_o   command handshake; cmd_we_i, cmd_addr_i, cmd_wdata_i
//   rsp_valid_o           one-cycle response strobe
//   rsp_rdata_o/rsp_err_o response data / timeout flag, held until next rsp
//   fll_req_o/fll_ack_i   FLL four-phase handshake (ack may equal req)
//   fll_wrn_o, fll_add_o, fll_data_o, fll_r_data_i   FLL command/data
//   fll_lock_i, clk_switch_en_i, clk_sel_o, locked_o  lock/clock select
// ---------------------------------------------------------------------------
module fll_cfg_ctrl
   import fll_cfg_pkg::*;
#(
   parameter int ACK_TIMEOUT = 256,
   parameter int LOCK_STABLE = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_we_i,
   input  logic [FLL_ADDR_W-1:0] cmd_addr_i,
   input  logic [FLL_DATA_W-1:0] cmd_wdata_i,
   output logic                  rsp_valid_o,
   output logic [FLL_DATA_W-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  fll_req_o,
   output logic                  fll_wrn_o,
   output logic [FLL_ADDR_W-1:0] fll_add_o,
   output logic [FLL_DATA_W-1:0] fll_data_o,
   input  logic                  fll_ack_i,
   input  logic [FLL_DATA_W-1:0] fll_r_data_i,
   input  logic                  fll_lock_i,
   input  logic                  clk_switch_en_i,
   output logic                  clk_sel_o,
   output logic                  locked_o
);

   localparam int               TO_W   = $clog2(ACK_TIMEOUT);
   localparam logic [TO_W-1:0]  TO_MAX = TO_W'(ACK_TIMEOUT - 1);

   fll_cfg_state_e        state_q, state_d;
   fll_cmd_t              cmd_q, cmd_d;
   logic                  req_q, req_d;
   logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
   logic [FLL_DATA_W-1:0] cap_rdata_q, cap_rdata_d;
   logic                  cap_err_q, cap_err_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [FLL_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;

   logic                  accept;
   logic                  shadow_rd;
   logic [FLL_DATA_W-1:0] shadow_rdata;

   // Ready is withheld in the reset cycle and while the FLL still drives ack
   // so a new req can never overlap an unreleased previous handshake.
   assign cmd_ready_o = (state_q == ST_IDLE) && !fll_ack_i && !rst_i;
   assign accept      = cmd_valid_i && cmd_ready_o;

   assign fll_req_o   = req_q;
   assign fll_wrn_o   = !cmd_q.we;
   assign fll_add_o   = cmd_q.addr;
   assign fll_data_o  = cmd_q.wdata;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

`ifdef FLL_CFG_SHADOW_EN
   logic [FLL_DATA_W-1:0] shadow_q [0:3];
   logic [FLL_DATA_W-1:0] shadow_d [0:3];

   assign shadow_rd    = accept && !cmd_we_i;
   assign shadow_rdata = shadow_q[cmd_addr_i];

   // Only a write acknowledged by the FLL updates the shadow; a timed-out
   // write never reaches the ack branch and leaves it untouched.
   always_comb begin
      shadow_d = shadow_q;
      if ((state_q == ST_REQ) && fll_ack_i && cmd_q.we) begin
         shadow_d[cmd_q.addr] = cmd_q.wdata;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow_q <= '{default: '0};
      end else begin
         shadow_q <= shadow_d;
      end
   end
`else
   assign shadow_rd    = 1'b0;
   assign shadow_rdata = '0;
`endif

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      req_d       = req_q;
      to_cnt_d    = to_cnt_q;
      cap_rdata_d = cap_rdata_q;
      cap_err_d   = cap_err_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (shadow_rd) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = shadow_rdata;
               rsp_err_d   = 1'b0;
               state_d     = ST_RESP;
            end else if (accept) begin
               cmd_d    = '{we: cmd_we_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
               req_d    = 1'b1;
               to_cnt_d = '0;
               state_d  = ST_REQ;
            end
         end

         ST_REQ: begin
            // Ack is checked before the timeout so a late ack in the final
            // allowed cycle still completes successfully.
            if (fll_ack_i) begin
               cap_rdata_d = cmd_q.we ? '0 : fll_r_data_i;
               cap_err_d   = 1'b0;
               req_d       = 1'b0;
               state_d     = ST_WAIT_REL;
            end else if (to_cnt_q == TO_MAX) begin
               cap_rdata_d = '0;
               cap_err_d   = 1'b1;
               req_d       = 1'b0;
               state_d     = ST_WAIT_REL;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end

         ST_WAIT_REL: begin
            if (!fll_ack_i) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = cap_rdata_q;
               rsp_err_d   = cap_err_q;
               state_d     = ST_RESP;
            end
         end

         ST_RESP: begin
            to_cnt_d = '0;
            state_d  = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         cmd_q       <= '0;
         req_q       <= 1'b0;
         to_cnt_q    <= '0;
         cap_rdata_q <= '0;
         cap_err_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         req_q       <= req_d;
         to_cnt_q    <= to_cnt_d;
         cap_rdata_q <= cap_rdata_d;
         cap_err_q   <= cap_err_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   fll_lock_monitor #(
      .LOCK_STABLE (LOCK_STABLE)
   ) u_lock_monitor (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .fll_lock_i      (fll_lock_i),
      .clk_switch_en_i (clk_switch_en_i),
      .locked_o        (locked_o),
      .clk_sel_o       (clk_sel_o)
   );

endmodule

// File: tb/tb_fll_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fll_cfg_ctrl
//
// Directed bench for fll_cfg_ctrl with ACK_TIMEOUT=8 and LOCK_STABLE=4.
// The FLL side is modelled by ack_mode: 0 = ack tied low, 1 = ack equal to
// req, 2 = ack raised once req has been seen for ack_dly cycles and released
// two cycles after req drops.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fll_cfg_ctrl;

   localparam int ACK_TIMEOUT = 8;
   localparam int LOCK_STABLE = 4;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [1:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        fll_req;
   logic        fll_wrn;
   logic [1:0]  fll_add;
   logic [31:0] fll_data;
   logic        fll_ack;
   logic [31:0] fll_r_data;
   logic        fll_lock;
   logic        clk_switch_en;
   logic        clk_sel;
   logic        locked;

   int          ack_mode;
   int          ack_dly;
   logic        ack_drv;

   int          n_checks;
   int          n_errors;

   assign fll_ack = (ack_mode == 1) ? fll_req : ack_drv;

   fll_cfg_ctrl #(
      .ACK_TIMEOUT (ACK_TIMEOUT),
      .LOCK_STABLE (LOCK_STABLE)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .cmd_valid_i     (cmd_valid),
      .cmd_ready_o     (cmd_ready),
      .cmd_we_i        (cmd_we),
      .cmd_addr_i      (cmd_addr),
      .cmd_wdata_i     (cmd_wdata),
      .rsp_valid_o     (rsp_valid),
      .rsp_rdata_o     (rsp_rdata),
      .rsp_err_o       (rsp_err),
      .fll_req_o       (fll_req),
      .fll_wrn_o       (fll_wrn),
      .fll_add_o       (fll_add),
      .fll_data_o      (fll_data),
      .fll_ack_i       (fll_ack),
      .fll_r_data_i    (fll_r_data),
      .fll_lock_i      (fll_lock),
      .clk_switch_en_i (clk_switch_en),
      .clk_sel_o       (clk_sel),
      .locked_o        (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one command and follows it to its response. lat counts cycles
   // from the accept cycle to the rsp_valid cycle inclusive (-1 if none).
   task automatic do_cmd(input logic we, input logic [1:0] addr, input logic [31:0] wd,
                         output int lat, output int req_cyc, output int rdy_hi);
      int n;
      int rel;
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_addr  = addr;
      cmd_wdata = wd;
      check("ready_before_accept", {31'd0, cmd_ready}, 32'd1);
      tick();
      cmd_valid = 1'b0;
      n = 1; req_cyc = 0; rdy_hi = 0; rel = 0;
      while (!rsp_valid && n < 40) begin
         if (fll_req) req_cyc++;
         if (cmd_ready) rdy_hi++;
         if (ack_mode == 2) begin
            if (fll_req && req_cyc == ack_dly) begin
               ack_drv = 1'b1;
            end else if (!fll_req && ack_drv) begin
               rel++;
               if (rel == 2) ack_drv = 1'b0;
            end
         end
         tick();
         n++;
      end
      lat = rsp_valid ? n + 1 : -1;
   endtask

   initial begin
      int lat, rc, rdy, fall_l, fall_s, rise_l, rise_s, rsp_cnt;
      n_checks = 0; n_errors = 0;
      rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 2'd0; cmd_wdata = 32'd0;
      fll_r_data = 32'd0; fll_lock = 1'b0; clk_switch_en = 1'b0;
      ack_mode = 0; ack_dly = 0; ack_drv = 1'b0;

      // Reset values (rst still high here)
      tick(); tick(); tick();
      check("rst_req",       {31'd0, fll_req},   32'd0);
      check("rst_wrn",       {31'd0, fll_wrn},   32'd1);
      check("rst_add",       {30'd0, fll_add},   32'd0);
      check("rst_data",      fll_data,           32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rdata",     rsp_rdata,          32'd0);
      check("rst_err",       {31'd0, rsp_err},   32'd0);
      check("rst_ready",     {31'd0, cmd_ready}, 32'd0);
      check("rst_locked",    {31'd0, locked},    32'd0);
      check("rst_clk_sel",   {31'd0, clk_sel},   32'd0);
      rst = 1'b0;
      tick();
      check("idle_ready", {31'd0, cmd_ready}, 32'd1);

      // Ready follows !ack in IDLE
      ack_drv = 1'b1;
      #1;
      check("ready_blocked_by_ack", {31'd0, cmd_ready}, 32'd0);
      ack_drv = 1'b0;
      #1;

      // Combinational ack write
      ack_mode = 1;
      do_cmd(1'b1, 2'd2, 32'h0000_1234, lat, rc, rdy);
      check("wr_latency",  lat, 32'd4);
      check("wr_req_cyc",  rc,  32'd1);
      check("wr_err",      {31'd0, rsp_err}, 32'd0);
      check("wr_rdata",    rsp_rdata, 32'd0);
      check("wr_fll_wrn",  {31'd0, fll_wrn}, 32'd0);
      check("wr_fll_add",  {30'd0, fll_add}, 32'd2);
      check("wr_fll_data", fll_data, 32'h0000_1234);
      tick();
      check("wr_rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);

      // Read with ack delayed 5 cycles
      ack_mode = 2; ack_dly = 6; fll_r_data = 32'hCAFE_0001;
      do_cmd(1'b0, 2'd1, 32'h0, lat, rc, rdy);
      check("rd_req_cyc",  rc,  32'd6);
      check("rd_ready_lo", rdy, 32'd0);
      check("rd_latency",  lat, 32'd10);
      check("rd_rdata",    rsp_rdata, 32'hCAFE_0001);
      check("rd_err",      {31'd0, rsp_err}, 32'd0);
      check("rd_fll_wrn",  {31'd0, fll_wrn}, 32'd1);
      check("rd_fll_add",  {30'd0, fll_add}, 32'd1);
      fll_r_data = 32'h0;
      tick();
      check("rd_rdata_hold", rsp_rdata, 32'hCAFE_0001);

      // Ack arriving in the last allowed REQ cycle beats the timeout
      ack_dly = 8; fll_r_data = 32'h0000_BEEF;
      do_cmd(1'b0, 2'd0, 32'h0, lat, rc, rdy);
      check("edge_req_cyc", rc, 32'd8);
      check("edge_err",     {31'd0, rsp_err}, 32'd0);
      check("edge_rdata",   rsp_rdata, 32'h0000_BEEF);
      tick();

      // Timeout with ack tied low
      ack_mode = 0; fll_r_data = 32'h0000_DEAD;
      do_cmd(1'b0, 2'd3, 32'h0, lat, rc, rdy);
      check("to_req_cyc", rc, 32'd8);
      check("to_latency", lat, 32'd11);
      check("to_err",     {31'd0, rsp_err}, 32'd1);
      check("to_rdata",   rsp_rdata, 32'd0);
      tick();
      check("to_err_hold", {31'd0, rsp_err}, 32'd1);

      // Next command after a timeout works normally
      ack_mode = 1;
      do_cmd(1'b1, 2'd0, 32'h0000_0005, lat, rc, rdy);
      check("after_to_latency", lat, 32'd4);
      check("after_to_err",     {31'd0, rsp_err}, 32'd0);
      tick();

`ifdef FLL_CFG_SHADOW_EN
      // Shadow: write, then read back without FLL handshake
      do_cmd(1'b1, 2'd3, 32'h0000_00A5, lat, rc, rdy);
      check("sh_wr_latency", lat, 32'd4);
      tick();
      ack_mode = 0;
      do_cmd(1'b0, 2'd3, 32'h0, lat, rc, rdy);
      check("sh_rd_latency", lat, 32'd2);
      check("sh_rd_req_cyc", rc,  32'd0);
      check("sh_rd_rdata",   rsp_rdata, 32'h0000_00A5);
      check("sh_rd_err",     {31'd0, rsp_err}, 32'd0);
      tick();
      // Timed-out write must not alter the shadow
      do_cmd(1'b1, 2'd3, 32'h0000_00FF, lat, rc, rdy);
      check("sh_to_err", {31'd0, rsp_err}, 32'd1);
      tick();
      do_cmd(1'b0, 2'd3, 32'h0, lat, rc, rdy);
      check("sh_rd_after_to", rsp_rdata, 32'h0000_00A5);
      tick();
      ack_mode = 1;
`endif

      // Lock qualification with switch enabled
      clk_switch_en = 1'b1;
      fll_lock = 1'b1;
      rise_l = -1; rise_s = -1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (locked && rise_l < 0) rise_l = i;
         if (clk_sel && rise_s < 0) rise_s = i;
      end
      check("lock_rise",    rise_l, 32'd6);
      check("clksel_rise",  rise_s, 32'd7);
      check("lock_sat",     {31'd0, locked}, 32'd1);

      // One-cycle lock glitch, then full re-qualification
      fll_lock = 1'b0;
      tick();
      fll_lock = 1'b1;
      fall_l = -1; fall_s = -1; rise_l = -1; rise_s = -1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (!locked && fall_l < 0) fall_l = i;
         if (!clk_sel && fall_s < 0) fall_s = i;
         if (locked && fall_l > 0 && rise_l < 0) rise_l = i;
         if (clk_sel && fall_s > 0 && rise_s < 0) rise_s = i;
      end
      check("glitch_lock_fall",   fall_l, 32'd2);
      check("glitch_clksel_fall", fall_s, 32'd2);
      check("relock_rise",        rise_l, 32'd6);
      check("relock_clksel_rise", rise_s, 32'd7);

      // Switch permission gating
      clk_switch_en = 1'b0;
      tick(); tick();
      check("en0_locked",  {31'd0, locked},  32'd1);
      check("en0_clk_sel", {31'd0, clk_sel}, 32'd0);
      clk_switch_en = 1'b1;
      tick();
      check("en1_clk_sel", {31'd0, clk_sel}, 32'd1);

      // Reset in the middle of a REQ phase
      ack_mode = 0;
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 2'd1; cmd_wdata = 32'h0000_7777;
      tick();
      cmd_valid = 1'b0;
      tick();
      check("pre_rst_req", {31'd0, fll_req}, 32'd1);
      rst = 1'b1;
      #1;
      check("rst_cycle_ready", {31'd0, cmd_ready}, 32'd0);
      tick();
      check("mid_rst_req",     {31'd0, fll_req},   32'd0);
      check("mid_rst_ready",   {31'd0, cmd_ready}, 32'd0);
      check("mid_rst_wrn",     {31'd0, fll_wrn},   32'd1);
      check("mid_rst_add",     {30'd0, fll_add},   32'd0);
      check("mid_rst_data",    fll_data,           32'd0);
      check("mid_rst_locked",  {31'd0, locked},    32'd0);
      check("mid_rst_clk_sel", {31'd0, clk_sel},   32'd0);
      check("mid_rst_rdata",   rsp_rdata,          32'd0);
      rst = 1'b0;
      rsp_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (rsp_valid) rsp_cnt++;
      end
      check("abort_no_rsp",  rsp_cnt, 32'd0);
      check("abort_idle",    {31'd0, cmd_ready}, 32'd1);
      check("abort_req_low", {31'd0, fll_req},   32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fll_cfg_ctrl.md
Name: fll_cfg_ctrl

Overview:
- Bus-side controller for the FLL configuration port of the clock/reset generator.
- Turns single-beat register commands (valid/ready) into the FLL req/ack handshake and returns read data or an error response.
- Monitors the FLL lock indication and drives the clock-select that switches the SoC clock from the reference clock to the FLL clock only after lock has been stable long enough.

Parameters:
- ACK_TIMEOUT, 256: cycles to wait for fll_ack_i before aborting with error; range 2..65535.
- LOCK_STABLE, 64: consecutive synchronised-lock cycles required before clk_sel_o may assert; range 1..65535.

Ports:
- clk_i  in  1  reference clock; all logic in this single domain.
- rst_i  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted in the cycle where valid && ready.
- cmd_we_i  in  1  1=write, 0=read.
- cmd_addr_i  in  2  FLL register address.
- cmd_wdata_i  in  32  write data.
- rsp_valid_o  out  1  one-cycle response strobe.
- rsp_rdata_o  out  32  read data; 0 for writes and errors.
- rsp_err_o  out  1  ack timeout.
- fll_req_o  out  1  FLL config request.
- fll_wrn_o  out  1  0=write, 1=read.
- fll_add_o  out  2  FLL address.
- fll_data_o  out  32  FLL write data.
- fll_ack_i  in  1  FLL ack; may be combinationally equal to fll_req_o.
- fll_r_data_i  in  32  FLL read data, valid while fll_ack_i is high.
- fll_lock_i  in  1  FLL lock; asynchronous to clk_i.
- clk_switch_en_i  in  1  software permission to run from the FLL.
- clk_sel_o  out  1  0=reference clock, 1=FLL clock.
- locked_o  out  1  lock stable for LOCK_STABLE cycles.

Behaviour:
- Reset values: every output is 0, except fll_wrn_o=1. The FSM is in IDLE and all counters are 0.
- FSM states are IDLE, REQ, WAIT_REL and RESP.
- IDLE:
  - cmd_ready_o = !fll_ack_i (combinational).
  - On acceptance, register we, addr and wdata onto fll_wrn_o=!we, fll_add_o and fll_data_o.
  - Set fll_req_o=1 and go to REQ. fll_req_o rises the cycle after acceptance.
- REQ:
  - fll_req_o is held and the timeout counter increments each cycle.
  - If fll_ack_i is sampled high (including the first REQ cycle), capture fll_r_data_i (reads only; writes capture 0), drop fll_req_o next cycle, and go to WAIT_REL.
  - Else if the counter reaches ACK_TIMEOUT-1, drop fll_req_o, set the error flag, and go to WAIT_REL.
  - Ack and timeout in the same cycle: ack wins, no error.
- WAIT_REL:
  - Wait for fll_ack_i=0 (four-phase release), then go to RESP.
  - If ack is already low, leave after 1 cycle.
- RESP:
  - rsp_valid_o=1 for exactly one cycle, with rsp_rdata_o/rsp_err_o.
  - Clear the counter and go to IDLE.
  - rsp_rdata_o/rsp_err_o hold their values until the next response.
- Latency with a combinational ack is 4 cycles, acceptance to rsp_valid_o: accept, REQ, WAIT_REL, RESP.
- cmd_ready_o is 0 outside IDLE. Commands are never dropped and never queued.
- Lock monitor:
  - fll_lock_i passes through a 2-flop synchroniser.
  - A saturating counter increments while the synchronised lock is 1 and clears to 0 in the cycle it is 0.
  - locked_o = (counter == LOCK_STABLE).
- Clock select:
  - clk_sel_o (registered) = locked_o && clk_switch_en_i.
  - Loss of synchronised lock drops locked_o and clk_sel_o in the next cycle, which reverts to the reference clock.
  - Re-lock requires the full LOCK_STABLE again.
- Reset asserted mid-transaction:
  - fll_req_o drops the next cycle and the FSM returns to IDLE.
  - No response is produced for the aborted command.
  - In the reset cycle itself, cmd_ready_o=0.

Optional Feature:
- FLL_CFG_SHADOW_EN defined:
  - Four 32-bit shadow registers, reset 0, are updated on each write that completes without error. A write that times out leaves the shadow unchanged.
  - Reads bypass the FLL: accept, then RESP next cycle (2-cycle latency). fll_req_o stays 0, rsp_rdata_o = shadow[addr], rsp_err_o = 0.
- Not defined:
  - No shadow storage; all reads use the FLL handshake.

Decomposition:
- Package fll_cfg_pkg holds:
  - the FSM state enum fll_cfg_state_e;
  - localparam FLL_ADDR_W=2 and FLL_DATA_W=32;
  - a command struct fll_cmd_t {we, addr, wdata}.
- Counter widths are derived from the parameters with $clog2.
- One sub-module, fll_lock_monitor, contains the synchroniser, stability counter, locked_o and clk_sel_o register.

Test Plan:
- Combinational ack (ack=req), write addr=2 data=0x0000_1234:
  - fll_req_o high for 1 cycle with fll_wrn_o=0, fll_add_o=2, fll_data_o=0x1234.
  - rsp_valid_o 4 cycles after acceptance, rsp_err_o=0.
- Read addr=1, ack delayed 5 cycles, fll_r_data_i=0xCAFE_0001:
  - rsp_rdata_o=0xCAFE0001.
  - fll_req_o held 6 cycles.
  - cmd_ready_o=0 throughout.
- ack tied 0, ACK_TIMEOUT=8:
  - fll_req_o drops after 8 REQ cycles.
  - rsp_err_o=1, rsp_rdata_o=0.
  - The next command is accepted normally.
- LOCK_STABLE=4, clk_switch_en_i=1, fll_lock_i held high:
  - locked_o rises 6 cycles after lock (2 sync + 4), clk_sel_o one cycle later.
  - A 1-cycle lock glitch low drops both, and the full count restarts.
- clk_switch_en_i=0 with a stable lock:
  - locked_o=1, clk_sel_o=0.
  - Raising enable sets clk_sel_o the next cycle.
- rst_i pulsed during REQ:
  - fll_req_o=0 and cmd_ready_o=0 the cycle after rst_i rises.
  - No rsp_valid_o.
  - All outputs at reset values.
  - With FLL_CFG_SHADOW_EN, a write of 0xA5 to addr 3 and then a read of addr 3 returns 0xA5 in 2 cycles with no fll_req_o.
